// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared store-buffer types, defaults and address helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:2] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    function automatic logic [SB_AW-1:2] sb_word(input logic [SB_AW-1:0] addr);
        return addr[SB_AW-1:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_match.sv
// ============================================================================
// Module      : sb_match
// Description : Youngest-match search of buffered stores against a load word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_match
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [AW-1:2]              addr_i [DEPTH],
    input  logic [DW-1:0]              data_i [DEPTH],
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
    input  logic [AW-1:2]              ldword_i,
    output logic                       hit_o,
    output logic [DW-1:0]              data_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w-1:0] w_idx;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = wr_ptr_i - c_ptr_w'(k);
            if (valid_i[w_idx] && (addr_i[w_idx] == ldword_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[w_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between the memory stage and a req/ack bus.
//               Load forwarding is built when STORE_BUF_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwriteM,
    input  logic [AW-1:0]              aluoutM,
    input  logic [DW-1:0]              writedataM,
    output logic                       stall,
    output logic                       bus_req,
    output logic [AW-1:0]              bus_addr,
    output logic [DW-1:0]              bus_wdata,
    input  logic                       bus_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              ldaddr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;
    logic [AW-1:2]      addr_q [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    // Full comes from registered count only, so a same-cycle ack never admits a push.
    assign w_full  = (count_q == c_cnt_w'(DEPTH));
    assign w_push  = memwriteM && !w_full;
    assign w_pop   = bus_req && bus_ack;

    assign stall     = memwriteM && w_full;
    assign empty     = (count_q == '0);
    assign bus_req   = !empty;
    assign bus_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign bus_wdata = data_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + c_ptr_w'(w_push);
        rd_ptr_d = rd_ptr_q + c_ptr_w'(w_pop);
        count_d  = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[wr_ptr_q] <= aluoutM[AW-1:2];
            data_q[wr_ptr_q] <= writedataM;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH-1:0] w_valid;

    // An entry is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign w_valid[gi] = ({1'b0, c_ptr_w'(gi) - rd_ptr_q}) < count_q;
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_sb_match (
        .addr_i   (addr_q),
        .data_i   (data_q),
        .valid_i  (w_valid),
        .wr_ptr_i (wr_ptr_q),
        .ldword_i (ldaddr[AW-1:2]),
        .hit_o    (fwd_hit),
        .data_o   (fwd_data)
    );

    logic unused_bits;
    assign unused_bits = ^{aluoutM[1:0], ldaddr[1:0]};
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;

    logic unused_bits;
    assign unused_bits = ^{aluoutM[1:0], ldaddr};
`endif

endmodule

`default_nettype wire
